// File: rtl/seg_scan_driver.sv
// Six-digit multiplexed seven-segment scan driver.
// Captures six hex digits into a pending buffer on load. The digits move into
// the display buffer only at a frame boundary, so no frame mixes old and new
// digits. One digit is lit per CLK_DIV-cycle slot, d1 first.
// Ports:
//   clk, rst_n    - clock (rising edge) and async active-low reset
//   d1..d6        - digit values, d1 leftmost
//   load          - capture strobe for d1..d6
//   enable        - display on when high
//   seg           - segments {g,f,e,d,c,b,a}, active-low, registered
//   an            - anodes, an[5]=d1 .. an[0]=d6, active-low, registered
//   frame_done    - one-cycle pulse after the last slot of each frame
module seg_scan_driver #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic [3:0] d6,
  input  logic       load,
  input  logic       enable,
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       frame_done
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);
  localparam logic [2:0] IDX_LAST = 3'd5;
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [5:0] AN_OFF = 6'h3F;

  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [2:0]       idx, idx_nxt;
  // Entry [0] holds d1, entry [5] holds d6.
  logic [5:0][3:0]  pending, pending_nxt;
  logic [5:0][3:0]  display, display_nxt;
  logic [5:0][3:0]  live;
  logic [3:0]       sel_digit;
  logic [6:0]       seg_nxt;
  logic [5:0]       an_nxt;
  logic             tick;
  logic             frame_end;

  assign live      = {d6, d5, d4, d3, d2, d1};
  assign tick      = enable && (cnt == CNT_MAX);
  assign frame_end = tick && (idx == IDX_LAST);

  // Hex digit to active-low gfedcba pattern.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0:    s = 7'h40;
      4'h1:    s = 7'h79;
      4'h2:    s = 7'h24;
      4'h3:    s = 7'h30;
      4'h4:    s = 7'h19;
      4'h5:    s = 7'h12;
      4'h6:    s = 7'h02;
      4'h7:    s = 7'h78;
      4'h8:    s = 7'h00;
      4'h9:    s = 7'h10;
      4'hA:    s = 7'h08;
      4'hB:    s = 7'h03;
      4'hC:    s = 7'h46;
      4'hD:    s = 7'h21;
      4'hE:    s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  // Prescaler, scan index and digit buffer next-state.
  always_comb begin
    cnt_nxt     = cnt;
    idx_nxt     = idx;
    pending_nxt = load ? live : pending;
    display_nxt = display;
    if (!enable) begin
      // Parked at slot 0 so re-enable lights d1 for a full period.
      cnt_nxt     = '0;
      idx_nxt     = '0;
      display_nxt = pending;
    end else if (tick) begin
      cnt_nxt = '0;
      if (idx == IDX_LAST) begin
        idx_nxt     = '0;
        // A load on the boundary edge goes straight to the display.
        display_nxt = load ? live : pending;
      end else begin
        idx_nxt = idx + 3'd1;
      end
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  // Digit selected by the current scan slot.
  always_comb begin
    sel_digit = display[0];
    case (idx)
      3'd1:    sel_digit = display[1];
      3'd2:    sel_digit = display[2];
      3'd3:    sel_digit = display[3];
      3'd4:    sel_digit = display[4];
      3'd5:    sel_digit = display[5];
      default: sel_digit = display[0];
    endcase
  end

  // Pin values, registered one cycle behind idx/display.
  always_comb begin
    seg_nxt = SEG_OFF;
    an_nxt  = AN_OFF;
    if (enable) begin
      seg_nxt = decode(sel_digit);
      case (idx)
        3'd0:    an_nxt = 6'b011111;
        3'd1:    an_nxt = 6'b101111;
        3'd2:    an_nxt = 6'b110111;
        3'd3:    an_nxt = 6'b111011;
        3'd4:    an_nxt = 6'b111101;
        3'd5:    an_nxt = 6'b111110;
        default: an_nxt = AN_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      pending    <= '0;
      display    <= '0;
      seg        <= SEG_OFF;
      an         <= AN_OFF;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      pending    <= pending_nxt;
      display    <= display_nxt;
      seg        <= seg_nxt;
      an         <= an_nxt;
      frame_done <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed, self-checking bench for seg_scan_driver with CLK_DIV=4.
module tb_seg_scan_driver;

  typedef logic [5:0][3:0] frame_t;  // [0]=d1 .. [5]=d6
  typedef struct {
    logic [3:0] dig;
    logic [6:0] seg;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] d1, d2, d3, d4, d5, d6;
  logic       load, enable;
  logic [6:0] seg;
  logic [5:0] an;
  logic       frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs[16];

  seg_scan_driver #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6),
    .load(load), .enable(enable),
    .seg(seg), .an(an), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic frame_t mk(input logic [3:0] a, b, c, d, e, f);
    frame_t r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = d; r[4] = e; r[5] = f;
    return r;
  endfunction

  task automatic set_d(input frame_t f);
    d1 = f[0]; d2 = f[1]; d3 = f[2]; d4 = f[3]; d5 = f[4]; d6 = f[5];
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_off(input string tag);
    check({tag, " seg"}, 32'(seg), 32'h7F);
    check({tag, " an"}, 32'(an), 32'h3F);
    check({tag, " frame_done"}, 32'(frame_done), 32'h0);
  endtask

  // Samples slots [from,to) of a frame that started at slot 0 with the
  // given displayed digits: anode walk, decoded segments, frame pulse, and
  // the at-most-one-anode-low rule.
  task automatic check_cycles(input int from, input int to, input frame_t digs);
    logic [5:0] e_an;
    for (int i = from; i < to; i++) begin
      step();
      e_an = ~(6'b100000 >> (i / 4));
      check($sformatf("an slot %0d", i), 32'(an), 32'(e_an));
      check($sformatf("seg slot %0d", i), 32'(seg), 32'(vecs[digs[i / 4]].seg));
      check($sformatf("frame_done slot %0d", i), 32'(frame_done), 32'(i == 23));
      check("one anode low", 32'($countones(~an) <= 1), 32'h1);
    end
  endtask

  initial begin
    frame_t zf, pf, af, lf;
    vecs[0]  = '{4'h0, 7'h40}; vecs[1]  = '{4'h1, 7'h79};
    vecs[2]  = '{4'h2, 7'h24}; vecs[3]  = '{4'h3, 7'h30};
    vecs[4]  = '{4'h4, 7'h19}; vecs[5]  = '{4'h5, 7'h12};
    vecs[6]  = '{4'h6, 7'h02}; vecs[7]  = '{4'h7, 7'h78};
    vecs[8]  = '{4'h8, 7'h00}; vecs[9]  = '{4'h9, 7'h10};
    vecs[10] = '{4'hA, 7'h08}; vecs[11] = '{4'hB, 7'h03};
    vecs[12] = '{4'hC, 7'h46}; vecs[13] = '{4'hD, 7'h21};
    vecs[14] = '{4'hE, 7'h06}; vecs[15] = '{4'hF, 7'h0E};
    zf = mk(0, 0, 0, 0, 0, 0);
    pf = mk(1, 0, 1, 1, 0, 0);
    af = mk(4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF);
    lf = mk(3, 4, 5, 6, 7, 8);

    // Reset held: load and enable must be ignored.
    rst_n = 1'b0; enable = 1'b1; load = 1'b1;
    set_d(mk(5, 5, 5, 5, 5, 5));
    repeat (3) step();
    check_off("reset");
    load = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Free-running scan of zeros, two frames.
    check_cycles(0, 24, zf);

    // Mid-frame load is deferred to the next frame.
    check_cycles(0, 6, zf);
    set_d(pf); load = 1'b1;
    check_cycles(6, 7, zf);
    load = 1'b0; set_d(mk(9, 9, 9, 9, 9, 9));
    check_cycles(7, 24, zf);
    check_cycles(0, 24, pf);

    // Load on the boundary tick shows up in the very next frame.
    check_cycles(0, 23, pf);
    set_d(af); load = 1'b1;
    check_cycles(23, 24, pf);
    load = 1'b0; set_d(mk(2, 2, 2, 2, 2, 2));
    check_cycles(0, 24, af);

    // Load held high: the last value before the boundary wins.
    load = 1'b1; set_d(mk(9, 9, 9, 9, 9, 9));
    check_cycles(0, 23, af);
    set_d(lf);
    check_cycles(23, 24, af);
    load = 1'b0; set_d(mk(1, 1, 1, 1, 1, 1));

    // Disable mid-frame, then re-enable from slot 0.
    check_cycles(0, 10, lf);
    enable = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      check_off("disabled");
    end
    enable = 1'b1;
    check_cycles(0, 24, lf);

    // Asynchronous reset between edges discards a pending capture.
    check_cycles(0, 9, lf);
    set_d(mk(5, 5, 5, 5, 5, 5)); load = 1'b1;
    check_cycles(9, 10, lf);
    load = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_off("async reset");
    @(negedge clk);
    rst_n = 1'b1;
    check_cycles(0, 24, zf);

    // Decode table: all six digits equal, enable from a disabled start.
    enable = 1'b0;
    step();
    foreach (vecs[v]) begin
      set_d(mk(vecs[v].dig, vecs[v].dig, vecs[v].dig, vecs[v].dig, vecs[v].dig, vecs[v].dig));
      load = 1'b1;
      step();
      load = 1'b0;
      step();
      check_off($sformatf("table %0d off", v));
      enable = 1'b1;
      step();
      check($sformatf("table %0d seg", v), 32'(seg), 32'(vecs[v].seg));
      check($sformatf("table %0d an", v), 32'(an), 32'h1F);
      enable = 1'b0;
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL provide parameter: CLK_DIV, 50000, clock cycles each digit is lit (legal range 2..2^20).
REQ-002 SHALL have port: clk  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports: d1..d6  input  4 each  digit values, d1 leftmost, unsigned 0x0..0xF.
REQ-005 SHALL have port: load  input  1  capture strobe for d1..d6.
REQ-006 SHALL have port: enable  input  1  display on when high.
REQ-007 SHALL have port: seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-008 SHALL have port: an  output  6  digit anodes, an[5]=d1 .. an[0]=d6, active-low, registered.
REQ-009 SHALL have port: frame_done  output  1  one-cycle pulse at end of each 6-digit frame, registered.

Function
REQ-010 SHALL keep a pending register (6x4 bits); on each rising edge with load=1 it captures d1..d6.
REQ-011 SHALL keep a display register (6x4 bits); it updates from pending only at a frame boundary (tick with idx=5), so a frame never mixes old and new values.
REQ-012 SHALL, when load=1 on the same edge as a frame boundary, write the live d1..d6 into both pending and display registers.
REQ-013 SHALL run prescaler cnt 0..CLK_DIV-1, wrapping to 0; tick is asserted in the cycle where cnt==CLK_DIV-1.
REQ-014 SHALL run scan index idx 0..5, advancing on tick and wrapping 5->0; idx=k selects display digit k+1 and drives an[5-k] low.
REQ-015 SHALL drive an with exactly one bit low while enable=1, and never more than one bit low.
REQ-016 SHALL register seg/an one cycle after idx/display changes, giving a fixed latency of 1 clk from the idx update to the pin.
REQ-017 SHALL decode a digit to seg (hex, active-low gfedcba): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
REQ-018 SHALL pulse frame_done for exactly 1 cycle, one clk after the tick where idx=5.
REQ-019 SHALL, while enable=0: force cnt=0 and idx=0; drive seg=7F and an=3F; hold frame_done=0. Load capture keeps working. While disabled, display is copied from pending every cycle.
REQ-020 SHALL, on the first rising edge where enable goes 0->1, restart at idx=0. The d1 digit is then lit for a full CLK_DIV period.
REQ-021 SHALL, when load is held high continuously, capture every cycle, so the last value before the frame boundary is shown.

Reset
REQ-022 SHALL, on rst_n low, immediately and asynchronously clear: cnt=0, idx=0, pending=0, display=0, seg=7F, an=3F, frame_done=0.
REQ-023 SHALL ignore load and enable while rst_n is low; operation resumes on the first rising edge after rst_n deasserts.
REQ-024 SHALL, on reset asserted mid-frame, discard any pending capture; after release the display shows 000000.

Verification (CLK_DIV=4 in sim)
REQ-025 SHALL check: reset release, enable=1, no load -> 1 clk later seg=40, an=1F (011111); an then steps 2F,37,3B,3D,3E every 4 clks; frame_done pulses once per 24 clks.
REQ-026 SHALL check: load=1 for 1 clk with d1..d6=1,0,1,1,0,0 mid-frame -> current frame unchanged; next frame seg sequence 79,40,79,79,40,40.
REQ-027 SHALL check: load coincident with the idx=5 tick, d=A,b,C,d,E,F -> next frame shows 08,03,46,21,06,0E immediately.
REQ-028 SHALL check: enable dropped mid-frame -> next clk seg=7F, an=3F, no frame_done; re-enable -> an=1F for full 4 clks.
REQ-029 SHALL check: rst_n pulsed low asynchronously between edges mid-scan -> outputs 7F/3F without waiting for a clock; after release, display shows all zeros.
REQ-030 SHALL check: a scoreboard asserts at most one an bit low and that seg equals the decode of the selected digit on every cycle.
